// File: rtl/isa_pkg.sv
// Instruction-set constants shared between the program-load encoder and the core decoder.
// Field offsets give the LSB position of each bit range in the 32-bit word.
package isa_pkg;

   localparam logic [1:0] KIND_DP_REG = 2'b00;
   localparam logic [1:0] KIND_DP_IMM = 2'b01;
   localparam logic [1:0] KIND_MEM    = 2'b10;
   localparam logic [1:0] KIND_BR     = 2'b11;

   localparam logic [3:0] CMD_AND = 4'b0000;
   localparam logic [3:0] CMD_SUB = 4'b0010;
   localparam logic [3:0] CMD_ADD = 4'b0100;
   localparam logic [3:0] CMD_CMP = 4'b1010;
   localparam logic [3:0] CMD_CMN = 4'b1011;
   localparam logic [3:0] CMD_ORR = 4'b1100;

   localparam logic [3:0] COND_AL = 4'hE;

   localparam logic [1:0] OP_DP  = 2'b00;
   localparam logic [1:0] OP_MEM = 2'b01;
   localparam logic [2:0] OP_BR  = 3'b101;

   localparam int OFF_COND  = 28;
   localparam int OFF_OP    = 26;
   localparam int OFF_BR    = 25;
   localparam int OFF_I     = 25;
   localparam int OFF_P     = 24;
   localparam int OFF_LINK  = 24;
   localparam int OFF_U     = 23;
   localparam int OFF_B     = 22;
   localparam int OFF_W     = 21;
   localparam int OFF_CMD   = 21;
   localparam int OFF_S     = 20;
   localparam int OFF_L     = 20;
   localparam int OFF_RN    = 16;
   localparam int OFF_RD    = 12;
   localparam int OFF_RM    = 0;
   localparam int OFF_IMM12 = 0;
   localparam int OFF_IMM24 = 0;

   typedef enum logic {
      ST_FILL = 1'b0,
      ST_FULL = 1'b1
   } enc_state_e;

   function automatic logic is_dp_cmd_supported(input logic [3:0] cmd);
      return (cmd == CMD_ADD) || (cmd == CMD_SUB) || (cmd == CMD_AND) ||
             (cmd == CMD_ORR) || (cmd == CMD_CMP) || (cmd == CMD_CMN);
   endfunction

   function automatic logic is_compare_cmd(input logic [3:0] cmd);
      return (cmd == CMD_CMP) || (cmd == CMD_CMN);
   endfunction

endpackage

// File: rtl/instr_field_pack.sv
// Combinational packing of one field-level descriptor into the decoder's word layout,
// plus a flag telling whether the decoder can execute it.
module instr_field_pack
   import isa_pkg::*;
(
   input  logic [1:0]  kind_i,
   input  logic [3:0]  cmd_i,
   input  logic        s_i,
   input  logic        load_i,
   input  logic        up_i,
   input  logic [3:0]  rn_i,
   input  logic [3:0]  rd_i,
   input  logic [3:0]  rm_i,
   input  logic [23:0] imm_i,
   output logic [31:0] word_o,
   output logic        supported_o
);

   logic       s_eff;
   logic [3:0] rd_eff;

   // Compares never write a destination and always update the flags.
   always_comb begin
      s_eff  = s_i;
      rd_eff = rd_i;
      if (is_compare_cmd(cmd_i)) begin
         s_eff  = 1'b1;
         rd_eff = 4'h0;
      end
   end

   always_comb begin
      word_o      = '0;
      supported_o = 1'b1;
      word_o[OFF_COND +: 4] = COND_AL;
      case (kind_i)
         KIND_DP_REG, KIND_DP_IMM: begin
            word_o[OFF_OP +: 2]  = OP_DP;
            word_o[OFF_I]        = (kind_i == KIND_DP_IMM);
            word_o[OFF_CMD +: 4] = cmd_i;
            word_o[OFF_S]        = s_eff;
            word_o[OFF_RN +: 4]  = rn_i;
            word_o[OFF_RD +: 4]  = rd_eff;
            if (kind_i == KIND_DP_IMM) begin
               word_o[OFF_IMM12 +: 12] = imm_i[11:0];
            end else begin
               word_o[OFF_RM +: 4] = rm_i;
            end
            supported_o = is_dp_cmd_supported(cmd_i);
         end
         KIND_MEM: begin
            word_o[OFF_OP +: 2]     = OP_MEM;
            word_o[OFF_I]           = 1'b0;
            word_o[OFF_P]           = 1'b1;
            word_o[OFF_U]           = up_i;
            word_o[OFF_B]           = 1'b0;
            word_o[OFF_W]           = 1'b0;
            word_o[OFF_L]           = load_i;
            word_o[OFF_RN +: 4]     = rn_i;
            word_o[OFF_RD +: 4]     = rd_i;
            word_o[OFF_IMM12 +: 12] = imm_i[11:0];
         end
         default: begin
            word_o[OFF_BR +: 3]     = OP_BR;
            word_o[OFF_LINK]        = 1'b0;
            word_o[OFF_IMM24 +: 24] = imm_i;
         end
      endcase
   end

endmodule

// File: rtl/instr_encoder.sv
// Streaming instruction encoder: valid/ready descriptor intake, registered word/address output,
// fill counter with a FILL/FULL state machine and a sticky unsupported-descriptor flag.
module instr_encoder
   import isa_pkg::*;
#(
   parameter int ADDR_W = 6,
   parameter int DEPTH  = 64
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clear,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [1:0]        in_kind,
   input  logic [3:0]        in_cmd,
   input  logic              in_s,
   input  logic              in_load,
   input  logic              in_up,
   input  logic [3:0]        in_rn,
   input  logic [3:0]        in_rd,
   input  logic [3:0]        in_rm,
   input  logic [23:0]       in_imm,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [31:0]       out_instr,
   output logic [ADDR_W-1:0] out_addr,
   output logic [ADDR_W:0]   count,
   output logic              full,
   output logic              err
);

   // state | meaning
   // FILL  | accepting descriptors, count < DEPTH
   // FULL  | DEPTH words accepted, intake closed until clear or reset

   localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);
   localparam logic [ADDR_W:0] ONE_C   = {{ADDR_W{1'b0}}, 1'b1};

   enc_state_e        state_q;
   logic              out_valid_q;
   logic [31:0]       out_instr_q;
   logic [ADDR_W-1:0] out_addr_q;
   logic [ADDR_W:0]   count_q;
   logic [ADDR_W:0]   count_d;
   logic              full_q;
   logic              err_q;

   logic [31:0] pack_word;
   logic        pack_supported;
   logic        accept;

   instr_field_pack u_pack (
      .kind_i      (in_kind),
      .cmd_i       (in_cmd),
      .s_i         (in_s),
      .load_i      (in_load),
      .up_i        (in_up),
      .rn_i        (in_rn),
      .rd_i        (in_rd),
      .rm_i        (in_rm),
      .imm_i       (in_imm),
      .word_o      (pack_word),
      .supported_o (pack_supported)
   );

   assign in_ready = !clear && (state_q == ST_FILL) && (!out_valid_q || out_ready);
   assign accept   = in_valid && in_ready;
   assign count_d  = count_q + ONE_C;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_FILL;
         out_valid_q <= 1'b0;
         out_instr_q <= '0;
         out_addr_q  <= '0;
         count_q     <= '0;
         full_q      <= 1'b0;
         err_q       <= 1'b0;
      end else if (clear) begin
         state_q     <= ST_FILL;
         out_valid_q <= 1'b0;
         count_q     <= '0;
         full_q      <= 1'b0;
      end else begin
         if (accept && pack_supported) begin
            out_valid_q <= 1'b1;
            out_instr_q <= pack_word;
            out_addr_q  <= count_q[ADDR_W-1:0];
            count_q     <= count_d;
            if (count_d == DEPTH_C) begin
               state_q <= ST_FULL;
               full_q  <= 1'b1;
            end
         end else begin
            // An unsupported descriptor is swallowed without disturbing the output slot.
            if (out_ready) begin
               out_valid_q <= 1'b0;
            end
            if (accept) begin
               err_q <= 1'b1;
            end
         end
      end
   end

   assign out_valid = out_valid_q;
   assign out_instr = out_instr_q;
   assign out_addr  = out_addr_q;
   assign count     = count_q;
   assign full      = full_q;
   assign err       = err_q;

endmodule
